// File: rtl/mul_rr_sched_if.sv
// Bundle between the clients, the round-robin multiplier scheduler and the shared datapath.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface mul_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic [WIDTH-1:0]      data_in;
  logic                  ldA;
  logic                  ldB;
  logic                  ldP;
  logic                  clrP;
  logic                  decB;
  logic                  eqz;
  logic [WIDTH-1:0]      prod;

  modport master (
    input  req, a_in, b_in, eqz, prod,
    output gnt, done, result, data_in, ldA, ldB, ldP, clrP, decB
  );

  modport slave (
    output req, a_in, b_in, eqz, prod,
    input  gnt, done, result, data_in, ldA, ldB, ldP, clrP, decB
  );
endinterface

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler/sequencer sharing one repeated-addition multiplier datapath.
// Optional macro MUL_OPSWAP_EN: load the larger operand into A so RUN lasts min(A,B)+1 cycles.
module mul_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_rr_sched_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_data;
  logic             r_ldA;
  logic             r_ldB;
  logic             r_clrP;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_last;

  logic [IW-1:0]    w_win_idx;
  logic [IW-1:0]    w_cand;
  logic             w_win_vld;
  logic [IW-1:0]    w_sel_idx;
  logic [WIDTH-1:0] w_a_arr [NREQ];
  logic [WIDTH-1:0] w_b_arr [NREQ];
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_second;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = bus.a_in[g*WIDTH +: WIDTH];
    assign w_b_arr[g] = bus.b_in[g*WIDTH +: WIDTH];
  end

  // Scan downward so the nearest set bit after r_last is the one left standing.
  always_comb begin
    w_win_idx = r_last;
    w_cand    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand    = IW'((int'(r_last) + i) % NREQ);
      w_win_idx = bus.req[w_cand] ? w_cand : w_win_idx;
    end
  end

  assign w_win_vld = |bus.req;
  assign w_sel_idx = (r_state == S_IDLE) ? w_win_idx : r_idx;
  assign w_a       = w_a_arr[w_sel_idx];
  assign w_b       = w_b_arr[w_sel_idx];

`ifdef MUL_OPSWAP_EN
  assign w_first  = (w_a >= w_b) ? w_a : w_b;
  assign w_second = (w_a >= w_b) ? w_b : w_a;
`else
  assign w_first  = w_a;
  assign w_second = w_b;
`endif

  // Sequencer FSM with registered grant, done, result, operand bus and load strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_data   <= '0;
      r_ldA    <= 1'b0;
      r_ldB    <= 1'b0;
      r_clrP   <= 1'b0;
      r_idx    <= '0;
      r_last   <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_gnt   <= ONE_HOT0 << w_win_idx;
            r_idx   <= w_win_idx;
            r_data  <= w_first;
            r_ldA   <= 1'b1;
            r_state <= S_LDA;
          end
        end
        S_LDA: begin
          r_ldA   <= 1'b0;
          r_ldB   <= 1'b1;
          r_clrP  <= 1'b1;
          r_data  <= w_second;
          r_state <= S_LDB;
        end
        S_LDB: begin
          r_ldB   <= 1'b0;
          r_clrP  <= 1'b0;
          r_data  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.eqz) begin
            r_result <= bus.prod;
            r_done   <= ONE_HOT0 << r_idx;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_last  <= r_idx;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_data  <= '0;
          r_ldA   <= 1'b0;
          r_ldB   <= 1'b0;
          r_clrP  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.data_in = r_data;
  assign bus.ldA     = r_ldA;
  assign bus.ldB     = r_ldB;
  assign bus.clrP    = r_clrP;
  // Add/decrement follow eqz directly so the final RUN cycle adds nothing.
  assign bus.ldP     = (r_state == S_RUN) & ~bus.eqz;
  assign bus.decB    = (r_state == S_RUN) & ~bus.eqz;
endmodule
